control_unit_fsm: RTL
=====================

// Module: control_unit_fsm
// PURPOSE
//  Multi-cycle controller that sequences dataPath_core. Fetches the instruction addressed by PC,
//  decodes a LEGv8 subset and drives the datapath control word one state per clock. It also
//  reports status back: halted/illegal flags, current state and a retired-instruction count.
//  Sits between the top level and dataPath_core; IR and status come back from the datapath.
// PARAMETERS
//  MEM_WAIT  1   cycles mem_cs held per memory access (>=1); IR_load/w_reg on last cycle
//  CNT_W     16  width of retired-instruction counter
// PORTS
//  clock          in   1      rising-edge clock
//  reset          in   1      asynchronous, active-low reset
//  run            in   1      1 = leave IDLE and execute; sampled only in IDLE
//  IR_in          in   32     IR_out of datapath
//  status         in   4      {V,C,N,Z} latched flags of datapath
//  w_reg,C0,mem_cs,mem_write_en,IR_load,status_load  out 1 each  datapath strobes
//  k              out  32     immediate, sign/zero-extended per format
//  FS             out  5      ALU op: AND 00000, ORR 01100, ADD 01000, SUB 01001 (+C0=1)
//  size           out  2      memory access size; always 2'b11
//  SA,SB,DA       out  5 each register selects
//  add_tri_sel    out  1      address source: 0 = ALU, 1 = PC
//  data_tri_sel   out  2      bus source: 00 ALU, 01 regB, 11 memory
//  PC_sel         out  2      00 hold, 01 PC+4, 10 PC+k, 11 unused (never driven)
//  B_Sel          out  1      0 = regB, 1 = k into ALU B
//  state          out  3      current FSM state (encoding below)
//  halted         out  1      1 in HALT
//  illegal        out  1      sticky; set when HALT entered on unknown opcode
//  retired        out  CNT_W  instructions completed, wraps to 0
// BEHAVIOUR
//  Reset (async, reset==0): state=IDLE, all strobes 0, k=0, FS=0, SA=SB=DA=0, PC_sel=00,
//   selects 0, size=11, illegal=0, retired=0. Applies mid-instruction: no partial write completes.
//  States: IDLE 0, FETCH 1, DECODE 2, EXEC 3, MEM 4, BRANCH 5, HALT 7. Moore outputs; default
//   all strobes 0 and PC_sel=00 in any state not listed below.
//  IDLE: run=1 -> FETCH.
//  FETCH: add_tri_sel=1, mem_cs=1 for MEM_WAIT cycles; IR_load=1 on last cycle -> DECODE.
//  DECODE: strobes 0; classify IR_in[31:21]:
//   ADD 10001011000 / SUB 11001011000 / AND 10001010000 / ORR 10101010000 (R)
//   ADDI 1001000100x / SUBI 1101000100x (I) / LDUR 11111000010 / STUR 11111000000 (D)
//   B 000101xxxxx / CBZ 10110100xxx; else -> HALT with illegal=1. Valid -> EXEC.
//  EXEC (1 cycle): fields SA=IR[9:5], SB=IR[20:16] (R) or IR[4:0] (STUR/CBZ), DA=IR[4:0].
//   R/I: data_tri_sel=00, w_reg=1, B_Sel=(I); I k=zero-ext IR[21:10]; SUB/SUBI C0=1;
//    PC_sel=01; retired+1 -> FETCH.
//   LDUR/STUR: FS=ADD, B_Sel=1, k=sext(IR[20:12]) -> MEM.
//   B: k=sext(IR[25:0])<<2, PC_sel=10; retired+1 -> FETCH.
//   CBZ: SA=IR[4:0], FS=ADD, B_Sel=1, k=0, status_load=1 -> BRANCH.
//  MEM (MEM_WAIT cycles): EXEC ALU controls held, add_tri_sel=0, mem_cs=1.
//   STUR: mem_write_en=1 all cycles, data_tri_sel=01, SB=Rt.
//   LDUR: data_tri_sel=11, DA=Rt; w_reg=1 on last cycle only.
//   Last cycle: PC_sel=01, retired+1 -> FETCH.
//  BRANCH: status[0]==1 -> k=sext(IR[23:5])<<2, PC_sel=10; else PC_sel=01; retired+1 -> FETCH.
//  HALT: absorbing until reset; strobes 0, PC_sel=00, halted=1.
//  PC advances exactly once per instruction, in its last state. Branch offsets are relative
//   to the branch's own address.
//  Writes with DA=31 are issued as decoded; XZR suppression is the register file's job.
//  w_reg and mem_write_en are never both 1 in the same cycle.
//  run=0 mid-instruction is ignored. Flow returns to FETCH, not IDLE, until reset.
// TESTING
//  1 Reset low mid-MEM of STUR, MEM_WAIT=3 -> mem_write_en=0 same cycle, state=0, retired=0.
//  2 ADDI X1,X0,#5 (0x91001401), X0=10 -> EXEC: w_reg=1, B_Sel=1, k=5, FS=01000;
//    X1=15; retired=1 after 3 cycles (MEM_WAIT=1).
//  3 SUB X2,X1,X0 (0xCB000022) -> FS=01001, C0=1, X2=5.
//  4 STUR X2,[X31,#8] then LDUR X4,[X31,#8] -> mem_write_en 1 cycle, addr 8; X4=5.
//  5 CBZ X5,#+3 with X5=0 -> BRANCH PC_sel=10, k=12. With X5=7 -> PC_sel=01.
//  6 B #-2 -> k=0xFFFFFFF8. IR=0xFFFFFFFF -> HALT, halted=1, illegal=1, held until reset.

Source files
------------

// File: rtl/control_unit_fsm_if.sv
// Control/status bus between control_unit_fsm (master) and dataPath_core (slave).
// Carries the run request, IR/flag feedback and the full datapath control word.
interface control_unit_fsm_if #(
  parameter int unsigned CNT_W = 16
);
  logic             run;
  logic [31:0]      IR_in;
  logic [3:0]       status;
  logic             w_reg;
  logic             C0;
  logic             mem_cs;
  logic             mem_write_en;
  logic             IR_load;
  logic             status_load;
  logic [31:0]      k;
  logic [4:0]       FS;
  logic [1:0]       size;
  logic [4:0]       SA;
  logic [4:0]       SB;
  logic [4:0]       DA;
  logic             add_tri_sel;
  logic [1:0]       data_tri_sel;
  logic [1:0]       PC_sel;
  logic             B_Sel;
  logic [2:0]       state;
  logic             halted;
  logic             illegal;
  logic [CNT_W-1:0] retired;

  modport master (
    input  run, IR_in, status,
    output w_reg, C0, mem_cs, mem_write_en, IR_load, status_load, k, FS, size,
           SA, SB, DA, add_tri_sel, data_tri_sel, PC_sel, B_Sel, state, halted,
           illegal, retired
  );

  modport slave (
    output run, IR_in, status,
    input  w_reg, C0, mem_cs, mem_write_en, IR_load, status_load, k, FS, size,
           SA, SB, DA, add_tri_sel, data_tri_sel, PC_sel, B_Sel, state, halted,
           illegal, retired
  );
endinterface

// File: rtl/control_unit_fsm.sv
// Multi-cycle LEGv8-subset controller for dataPath_core: fetch, decode and one
// registered control word per state, plus halted/illegal/retired status.
module control_unit_fsm #(
  parameter int unsigned MEM_WAIT = 1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic               clock,
  input  logic               reset,
  control_unit_fsm_if.master bus
);
  localparam int unsigned WAIT_W = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
  localparam logic [4:0]  FS_AND = 5'b00000;
  localparam logic [4:0]  FS_ORR = 5'b01100;
  localparam logic [4:0]  FS_ADD = 5'b01000;
  localparam logic [4:0]  FS_SUB = 5'b01001;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
    S_MEM = 3'd4, S_BRANCH = 3'd5, S_HALT = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    C_ADD, C_SUB, C_AND, C_ORR, C_ADDI, C_SUBI, C_LDUR, C_STUR, C_B, C_CBZ, C_ILL
  } cls_t;

  state_t            r_state, w_nxt_state;
  logic [WAIT_W-1:0] r_cnt, w_nxt_cnt;
  logic              w_last, w_nxt_last, w_retire;
  logic [31:0]       r_ir, w_ir;
  cls_t              w_cls;
  logic [31:0]       w_k_i, w_k_d, w_k_b, w_k_cb;
  logic [CNT_W-1:0]  r_retired;
  logic              r_illegal, r_halted;

  logic        r_w_reg, r_c0, r_mem_cs, r_mem_we, r_ir_load, r_st_load, r_add, r_bsel;
  logic        w_w_reg, w_c0, w_mem_cs, w_mem_we, w_ir_load, w_st_load, w_add, w_bsel;
  logic [31:0] r_k, w_k;
  logic [4:0]  r_fs, w_fs, r_sa, w_sa, r_sb, w_sb, r_da, w_da;
  logic [1:0]  r_dts, w_dts, r_pc_sel, w_pc_sel;

  // Upper flag bits are carried on the bus but only Z steers CBZ.
  logic w_unused_flags;
  assign w_unused_flags = ^bus.status[3:1];

  // IR is live from the datapath while decoding, then held locally for later states.
  assign w_ir   = (r_state == S_DECODE) ? bus.IR_in : r_ir;
  assign w_k_i  = {20'd0, w_ir[21:10]};
  assign w_k_d  = {{23{w_ir[20]}}, w_ir[20:12]};
  assign w_k_b  = {{4{w_ir[25]}}, w_ir[25:0], 2'b00};
  assign w_k_cb = {{11{w_ir[23]}}, w_ir[23:5], 2'b00};

  always_comb begin
    w_cls = C_ILL;
    casez (w_ir[31:21])
      11'b10001011000: w_cls = C_ADD;
      11'b11001011000: w_cls = C_SUB;
      11'b10001010000: w_cls = C_AND;
      11'b10101010000: w_cls = C_ORR;
      11'b1001000100?: w_cls = C_ADDI;
      11'b1101000100?: w_cls = C_SUBI;
      11'b11111000010: w_cls = C_LDUR;
      11'b11111000000: w_cls = C_STUR;
      11'b000101?????: w_cls = C_B;
      11'b10110100???: w_cls = C_CBZ;
      default:         w_cls = C_ILL;
    endcase
  end

  assign w_last = (r_cnt == WAIT_W'(MEM_WAIT - 1));

  // Next state, wait counter and retire pulse.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = '0;
    w_retire    = 1'b0;
    case (r_state)
      S_IDLE:   if (bus.run) w_nxt_state = S_FETCH;
      S_FETCH: begin
        if (w_last) w_nxt_state = S_DECODE;
        else        w_nxt_cnt   = r_cnt + WAIT_W'(1);
      end
      S_DECODE: w_nxt_state = (w_cls == C_ILL) ? S_HALT : S_EXEC;
      S_EXEC: begin
        case (w_cls)
          C_LDUR, C_STUR: w_nxt_state = S_MEM;
          C_CBZ:          w_nxt_state = S_BRANCH;
          default: begin
            w_nxt_state = S_FETCH;
            w_retire    = 1'b1;
          end
        endcase
      end
      S_MEM: begin
        if (w_last) begin
          w_nxt_state = S_FETCH;
          w_retire    = 1'b1;
        end else begin
          w_nxt_cnt = r_cnt + WAIT_W'(1);
        end
      end
      S_BRANCH: begin
        w_nxt_state = S_FETCH;
        w_retire    = 1'b1;
      end
      S_HALT:   w_nxt_state = S_HALT;
      default:  w_nxt_state = S_IDLE;
    endcase
  end

  assign w_nxt_last = (w_nxt_cnt == WAIT_W'(MEM_WAIT - 1));

  // Control word for the state about to be entered, so every strobe is a flop output.
  always_comb begin
    w_w_reg  = 1'b0; w_c0 = 1'b0; w_mem_cs = 1'b0; w_mem_we = 1'b0;
    w_ir_load = 1'b0; w_st_load = 1'b0; w_add = 1'b0; w_bsel = 1'b0;
    w_k = '0; w_fs = '0; w_sa = '0; w_sb = '0; w_da = '0;
    w_dts = 2'b00; w_pc_sel = 2'b00;
    case (w_nxt_state)
      S_FETCH: begin
        w_add     = 1'b1;
        w_mem_cs  = 1'b1;
        w_ir_load = w_nxt_last;
      end
      S_EXEC: begin
        w_sa = w_ir[9:5];
        w_sb = w_ir[20:16];
        w_da = w_ir[4:0];
        case (w_cls)
          C_ADD, C_SUB, C_AND, C_ORR, C_ADDI, C_SUBI: begin
            w_w_reg  = 1'b1;
            w_pc_sel = 2'b01;
            w_bsel   = (w_cls == C_ADDI) || (w_cls == C_SUBI);
            w_k      = w_bsel ? w_k_i : '0;
            w_c0     = (w_cls == C_SUB) || (w_cls == C_SUBI);
            case (w_cls)
              C_AND:   w_fs = FS_AND;
              C_ORR:   w_fs = FS_ORR;
              C_SUB,
              C_SUBI:  w_fs = FS_SUB;
              default: w_fs = FS_ADD;
            endcase
          end
          C_LDUR, C_STUR: begin
            w_fs   = FS_ADD;
            w_bsel = 1'b1;
            w_k    = w_k_d;
            if (w_cls == C_STUR) w_sb = w_ir[4:0];
          end
          C_B: begin
            w_k      = w_k_b;
            w_pc_sel = 2'b10;
          end
          C_CBZ: begin
            w_sa      = w_ir[4:0];
            w_sb      = w_ir[4:0];
            w_fs      = FS_ADD;
            w_bsel    = 1'b1;
            w_st_load = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        w_fs     = FS_ADD;
        w_bsel   = 1'b1;
        w_k      = w_k_d;
        w_sa     = w_ir[9:5];
        w_sb     = w_ir[20:16];
        w_da     = w_ir[4:0];
        w_mem_cs = 1'b1;
        w_pc_sel = w_nxt_last ? 2'b01 : 2'b00;
        if (w_cls == C_STUR) begin
          w_mem_we = 1'b1;
          w_dts    = 2'b01;
          w_sb     = w_ir[4:0];
        end else begin
          w_dts   = 2'b11;
          w_w_reg = w_nxt_last;
        end
      end
      S_BRANCH: w_k = w_k_cb;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;   r_cnt <= '0;      r_ir <= '0;
      r_w_reg <= 1'b0;     r_c0 <= 1'b0;     r_mem_cs <= 1'b0;  r_mem_we <= 1'b0;
      r_ir_load <= 1'b0;   r_st_load <= 1'b0; r_add <= 1'b0;    r_bsel <= 1'b0;
      r_k <= '0;           r_fs <= '0;       r_sa <= '0;        r_sb <= '0;
      r_da <= '0;          r_dts <= 2'b00;   r_pc_sel <= 2'b00;
      r_retired <= '0;     r_illegal <= 1'b0; r_halted <= 1'b0;
    end else begin
      r_state <= w_nxt_state;  r_cnt <= w_nxt_cnt;
      if (r_state == S_DECODE) r_ir <= bus.IR_in;
      r_w_reg <= w_w_reg;      r_c0 <= w_c0;       r_mem_cs <= w_mem_cs;  r_mem_we <= w_mem_we;
      r_ir_load <= w_ir_load;  r_st_load <= w_st_load; r_add <= w_add;    r_bsel <= w_bsel;
      r_k <= w_k;              r_fs <= w_fs;       r_sa <= w_sa;          r_sb <= w_sb;
      r_da <= w_da;            r_dts <= w_dts;     r_pc_sel <= w_pc_sel;
      r_halted <= (w_nxt_state == S_HALT);
      if (w_retire) r_retired <= r_retired + CNT_W'(1);
      if ((r_state == S_DECODE) && (w_nxt_state == S_HALT)) r_illegal <= 1'b1;
    end
  end

  assign bus.w_reg        = r_w_reg;
  assign bus.C0           = r_c0;
  assign bus.mem_cs       = r_mem_cs;
  assign bus.mem_write_en = r_mem_we;
  assign bus.IR_load      = r_ir_load;
  assign bus.status_load  = r_st_load;
  assign bus.k            = r_k;
  assign bus.FS           = r_fs;
  assign bus.size         = 2'b11;
  assign bus.SA           = r_sa;
  assign bus.SB           = r_sb;
  assign bus.DA           = r_da;
  assign bus.add_tri_sel  = r_add;
  assign bus.data_tri_sel = r_dts;
  assign bus.B_Sel        = r_bsel;
  assign bus.state        = r_state;
  assign bus.halted       = r_halted;
  assign bus.illegal      = r_illegal;
  assign bus.retired      = r_retired;
  // CBZ flags are latched by the datapath on entry to BRANCH, so the PC choice follows them there.
  assign bus.PC_sel = (r_state == S_BRANCH) ? (bus.status[0] ? 2'b10 : 2'b01) : r_pc_sel;
endmodule
